sync_start_scheduler: RTL

- Generates the row-rate `gen_sync_start` strobe that drives the sync/pipeline capture stage, together with the row index that stage latches on each rising edge.
- Sequences a readout as N frames of R rows, each row a fixed number of 20 MHz cycles, with start/stop control and completion pulses.
- Sits between the register bank and the sync-processing stage in the top level.

---
 rtl/sync_start_scheduler.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/sync_start_scheduler.sv
// Row-rate gen_sync_start generator: sequences N frames of R rows with start/stop control.
// Define SYNC_SCHED_FRAME_GAP_EN to add cfg_frame_gap and the blanking GAP state between frames.
module sync_start_scheduler #(
   parameter int CNT_W = 16
) (
   input  logic             clk_20mhz,
   input  logic             rst_20mhz,
   input  logic             start_i,
   input  logic             stop_i,
   input  logic [CNT_W-1:0] cfg_line_period,
   input  logic [CNT_W-1:0] cfg_sync_width,
   input  logic [CNT_W-1:0] cfg_rows,
   input  logic [CNT_W-1:0] cfg_frames,
`ifdef SYNC_SCHED_FRAME_GAP_EN
   input  logic [CNT_W-1:0] cfg_frame_gap,
`endif
   output logic             gen_sync_start,
   output logic [31:0]      active_repeat_count_o,
   output logic [CNT_W-1:0] frame_cnt_o,
   output logic             busy_o,
   output logic             frame_done_o,
   output logic             seq_done_o,
   output logic             cfg_err_o
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LINE,
`ifdef SYNC_SCHED_FRAME_GAP_EN
      ST_GAP,
`endif
      ST_DONE
   } state_t;

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] line_cnt_q, line_cnt_d;
   logic [CNT_W-1:0] row_q, row_d;
   logic [CNT_W-1:0] frame_q, frame_d;
   logic             stop_pend_q, stop_pend_d;

   logic [CNT_W-1:0] period_q, period_d;
   logic [CNT_W-1:0] width_q, width_d;
   logic [CNT_W-1:0] rows_q, rows_d;
   logic [CNT_W-1:0] frames_q, frames_d;
`ifdef SYNC_SCHED_FRAME_GAP_EN
   logic [CNT_W-1:0] gap_q, gap_d;
   logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
`endif

   logic             cfg_legal;
   logic             stop_now;
   logic             line_end;
   logic             last_row;
   logic             last_frame;
   logic             cfg_err_d;
   logic [CNT_W-1:0] row_out_q, row_out_d;

   // Legality is judged on the values being latched, so the error lands one cycle after start.
   assign cfg_legal = (cfg_line_period >= CNT_W'(2)) &&
                      (cfg_sync_width != '0) &&
                      (cfg_sync_width < cfg_line_period) &&
                      (cfg_rows != '0);

   assign stop_now   = stop_pend_q | stop_i;
   assign line_end   = (line_cnt_q == period_q - ONE);
   assign last_row   = (row_q == rows_q - ONE);
   assign last_frame = (frames_q != '0) && (frame_q == frames_q - ONE);

   // NOTE: every signal gets its hold value before the case so no path leaves it unassigned (no latches).
   always_comb begin
      state_d     = state_q;
      line_cnt_d  = line_cnt_q;
      row_d       = row_q;
      frame_d     = frame_q;
      stop_pend_d = stop_pend_q;
      period_d    = period_q;
      width_d     = width_q;
      rows_d      = rows_q;
      frames_d    = frames_q;
`ifdef SYNC_SCHED_FRAME_GAP_EN
      gap_d       = gap_q;
      gap_cnt_d   = gap_cnt_q;
`endif
      cfg_err_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            stop_pend_d = 1'b0;
            if (start_i && !stop_i) begin
               period_d = cfg_line_period;
               width_d  = cfg_sync_width;
               rows_d   = cfg_rows;
               frames_d = cfg_frames;
`ifdef SYNC_SCHED_FRAME_GAP_EN
               gap_d    = cfg_frame_gap;
`endif
               if (cfg_legal) begin
                  state_d    = ST_LINE;
                  line_cnt_d = '0;
                  row_d      = '0;
                  frame_d    = '0;
               end else begin
                  cfg_err_d = 1'b1;
               end
            end
         end

         ST_LINE: begin
            if (stop_i) stop_pend_d = 1'b1;
            if (!line_end) begin
               line_cnt_d = line_cnt_q + ONE;
            end else if (stop_now) begin
               state_d = ST_DONE;
            end else if (!last_row) begin
               row_d      = row_q + ONE;
               line_cnt_d = '0;
            end else if (last_frame) begin
               state_d = ST_DONE;
            end else begin
               row_d      = '0;
               frame_d    = frame_q + ONE;
               line_cnt_d = '0;
`ifdef SYNC_SCHED_FRAME_GAP_EN
               if (gap_q != '0) begin
                  state_d   = ST_GAP;
                  gap_cnt_d = '0;
               end
`endif
            end
         end

`ifdef SYNC_SCHED_FRAME_GAP_EN
         ST_GAP: begin
            if (stop_i) stop_pend_d = 1'b1;
            if (gap_cnt_q == gap_q - ONE) begin
               state_d    = stop_now ? ST_DONE : ST_LINE;
               line_cnt_d = '0;
            end else begin
               gap_cnt_d = gap_cnt_q + ONE;
            end
         end
`endif

         ST_DONE: begin
            state_d     = ST_IDLE;
            stop_pend_d = 1'b0;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // The row output only moves when a line starts, so it rises together with gen_sync_start.
   assign row_out_d = (state_d == ST_LINE) ? row_d : row_out_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_20mhz) begin
      if (rst_20mhz) begin
         state_q     <= ST_IDLE;
         line_cnt_q  <= '0;
         row_q       <= '0;
         frame_q     <= '0;
         stop_pend_q <= 1'b0;
         period_q    <= '0;
         width_q     <= '0;
         rows_q      <= '0;
         frames_q    <= '0;
`ifdef SYNC_SCHED_FRAME_GAP_EN
         gap_q       <= '0;
         gap_cnt_q   <= '0;
`endif
      end else begin
         state_q     <= state_d;
         line_cnt_q  <= line_cnt_d;
         row_q       <= row_d;
         frame_q     <= frame_d;
         stop_pend_q <= stop_pend_d;
         period_q    <= period_d;
         width_q     <= width_d;
         rows_q      <= rows_d;
         frames_q    <= frames_d;
`ifdef SYNC_SCHED_FRAME_GAP_EN
         gap_q       <= gap_d;
         gap_cnt_q   <= gap_cnt_d;
`endif
      end
   end

   // Outputs are flops loaded from next-state values, so they line up with the state they describe.
   always_ff @(posedge clk_20mhz) begin
      if (rst_20mhz) begin
         gen_sync_start        <= 1'b0;
         active_repeat_count_o <= '0;
         row_out_q             <= '0;
         frame_cnt_o           <= '0;
         busy_o                <= 1'b0;
         frame_done_o          <= 1'b0;
         seq_done_o            <= 1'b0;
         cfg_err_o             <= 1'b0;
      end else begin
         gen_sync_start        <= (state_d == ST_LINE) && (line_cnt_d < width_d);
         active_repeat_count_o <= 32'(row_out_d);
         row_out_q             <= row_out_d;
         frame_cnt_o           <= frame_d;
         busy_o                <= (state_d != ST_IDLE);
         frame_done_o          <= (state_d == ST_LINE) &&
                                  (line_cnt_d == period_d - ONE) &&
                                  (row_d == rows_d - ONE);
         seq_done_o            <= (state_d == ST_DONE);
         cfg_err_o             <= cfg_err_d;
      end
   end

endmodule
